// File: rtl/wb_ctrl_pkg.sv
// Shared types and helpers for the writeback controller.
package wb_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // RISC-V load funct3 encodings
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    // One queued load result: destination register plus formatted data
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ld_entry_t;

    // Select the addressed byte/half of an aligned word and extend it.
    // Unknown funct3 codes fall back to the full word.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] rdata
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = rdata[{addr_lo, 3'b000} +: 8];
        h = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   r = {{(XLEN-8){b[7]}}, b};
            F3_LH:   r = {{(XLEN-16){h[15]}}, h};
            F3_LBU:  r = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  r = {{(XLEN-16){1'b0}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// EX / LSU / regfile-write signal bundle around the writeback controller.
interface wb_ctrl_if;
    import wb_ctrl_pkg::*;

    logic                  ex_wen_i;
    logic [REG_ADDR_W-1:0] ex_waddr_i;
    logic [XLEN-1:0]       ex_wdata_i;
    logic                  ex_stall_o;
    logic                  ld_issue_i;
    logic [REG_ADDR_W-1:0] ld_issue_rd_i;
    logic                  lsu_rvalid_i;
    logic                  lsu_rready_o;
    logic [REG_ADDR_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]       lsu_rdata_i;
    logic [2:0]            lsu_funct3_i;
    logic [1:0]            lsu_addr_lo_i;
    logic                  rd_wen_o;
    logic [REG_ADDR_W-1:0] rd_waddr_o;
    logic [XLEN-1:0]       rd_wdata_o;
    logic [XLEN-1:0]       busy_o;

    // Writeback controller side
    modport slave (
        input  ex_wen_i, ex_waddr_i, ex_wdata_i,
        input  ld_issue_i, ld_issue_rd_i,
        input  lsu_rvalid_i, lsu_rd_i, lsu_rdata_i, lsu_funct3_i, lsu_addr_lo_i,
        output ex_stall_o, lsu_rready_o,
        output rd_wen_o, rd_waddr_o, rd_wdata_o, busy_o
    );

    // Pipeline / environment side
    modport master (
        output ex_wen_i, ex_waddr_i, ex_wdata_i,
        output ld_issue_i, ld_issue_rd_i,
        output lsu_rvalid_i, lsu_rd_i, lsu_rdata_i, lsu_funct3_i, lsu_addr_lo_i,
        input  ex_stall_o, lsu_rready_o,
        input  rd_wen_o, rd_waddr_o, rd_wdata_o, busy_o
    );

endinterface

// File: rtl/wb_ld_fifo.sv
// Small synchronous FIFO holding formatted load results until they win writeback.
module wb_ld_fifo
    import wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  ld_entry_t              push_data,
    input  logic                   pop,
    output ld_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    ld_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: merges EX results and queued load data onto the
// regfile write port, with a starvation guard and a pending-load scoreboard.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic      clk,
    input  logic      rst,
    wb_ctrl_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    ld_entry_t             push_entry;
    ld_entry_t             fifo_head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  ex_stall;
    logic                  fifo_win;
    logic                  ex_win;
    logic                  win;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [XLEN-1:0]       win_data;
    logic [SW-1:0]         starve_reg;
    logic [SW-1:0]         starve_next;
    logic [XLEN-1:0]       busy_reg;
    logic [XLEN-1:0]       busy_next;
    logic                  rd_wen_reg;
    logic [REG_ADDR_W-1:0] rd_waddr_reg;
    logic [XLEN-1:0]       rd_wdata_reg;

    // Load data is formatted on entry so the FIFO holds regfile-ready values
    assign push_entry.rd   = bus.lsu_rd_i;
    assign push_entry.data = load_extend(bus.lsu_funct3_i, bus.lsu_addr_lo_i, bus.lsu_rdata_i);
    assign bus.lsu_rready_o = (fifo_count != CW'(DEPTH));
    assign accept           = bus.lsu_rvalid_i && !fifo_full;

    wb_ld_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (fifo_win),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbitration: EX normally wins, but a waiting load is forced through
    // after STARVE_MAX consecutive EX wins
    always_comb begin
        ex_stall    = (fifo_count != '0) && (starve_reg == SW'(STARVE_MAX));
        fifo_win    = ex_stall || (!bus.ex_wen_i && !fifo_empty);
        ex_win      = !ex_stall && bus.ex_wen_i;
        win         = fifo_win || ex_win;
        win_addr    = fifo_win ? fifo_head.rd   : bus.ex_waddr_i;
        win_data    = fifo_win ? fifo_head.data : bus.ex_wdata_i;
        starve_next = starve_reg;
        if (fifo_win) begin
            starve_next = '0;
        end else if (ex_win) begin
            starve_next = fifo_empty ? '0 : starve_reg + 1'b1;
        end
    end

    assign bus.ex_stall_o = ex_stall;

    // Busy bits: a new issue sets, a registered FIFO write clears; set wins, x0 never busy
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_reg
            assign busy_next[gi] =
                (bus.ld_issue_i && bus.ld_issue_rd_i == REG_ADDR_W'(gi)) ||
                (busy_reg[gi] && !(fifo_win && fifo_head.rd == REG_ADDR_W'(gi)));
        end
    end

    // Register the winner onto the write port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_wen_reg   <= 1'b0;
            rd_waddr_reg <= '0;
            rd_wdata_reg <= '0;
            starve_reg   <= '0;
            busy_reg     <= '0;
        end else begin
            rd_wen_reg <= win && (win_addr != '0);
            if (win) begin
                rd_waddr_reg <= win_addr;
                rd_wdata_reg <= win_data;
            end
            starve_reg <= starve_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.rd_wen_o   = rd_wen_reg;
    assign bus.rd_waddr_o = rd_waddr_reg;
    assign bus.rd_wdata_o = rd_wdata_reg;
    assign bus.busy_o     = busy_reg;

    // A second load to a still-pending register (WAW) must be held off by ID,
    // unless that register is being released in the same cycle
    a_no_waw: assert property (@(posedge clk) disable iff (!rst)
        !(bus.ld_issue_i && bus.ld_issue_rd_i != '0 && busy_reg[bus.ld_issue_rd_i] &&
          !(fifo_win && fifo_head.rd == bus.ld_issue_rd_i)));

    // EX must never write a register with a load still outstanding
    a_no_ex_busy: assert property (@(posedge clk) disable iff (!rst)
        !(ex_win && bus.ex_waddr_i != '0 && busy_reg[bus.ex_waddr_i]));

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: reset, extension, starvation, backpressure,
// scoreboard and x0 handling with hand-computed expectations.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    wb_ctrl_if bus();

    wb_ctrl #(.DEPTH(2), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv_ex(input bit en, input logic [4:0] a, input logic [31:0] d);
        bus.ex_wen_i   = en;
        bus.ex_waddr_i = a;
        bus.ex_wdata_i = d;
    endtask

    task automatic drv_ld(input bit v, input logic [4:0] rd, input logic [31:0] d,
                          input logic [2:0] f3, input logic [1:0] lo);
        bus.lsu_rvalid_i  = v;
        bus.lsu_rd_i      = rd;
        bus.lsu_rdata_i   = d;
        bus.lsu_funct3_i  = f3;
        bus.lsu_addr_lo_i = lo;
    endtask

    task automatic drv_iss(input bit v, input logic [4:0] rd);
        bus.ld_issue_i    = v;
        bus.ld_issue_rd_i = rd;
    endtask

    task automatic idle();
        drv_ex(0, 5'd0, 32'h0);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        drv_iss(0, 5'd0);
    endtask

    // Combinational outputs, sampled just after inputs settle
    task automatic pre(input string tag, input bit stall, input bit rready);
        #1;
        chk({tag, "_stall"},  32'(bus.ex_stall_o),   32'(stall));
        chk({tag, "_rready"}, 32'(bus.lsu_rready_o), 32'(rready));
    endtask

    // Registered outputs after the next active edge
    task automatic post(input string tag, input bit wen, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chk({tag, "_wen"}, 32'(bus.rd_wen_o), 32'(wen));
        if (wen) begin
            chk({tag, "_waddr"}, 32'(bus.rd_waddr_o), 32'(a));
            chk({tag, "_wdata"}, bus.rd_wdata_o, d);
        end
    endtask

    // One load beat accepted, then drained by the FIFO on the following cycle
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] d,
                           input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp);
        drv_ld(1, rd, d, f3, lo);
        pre({tag, "_acc"}, 0, 1);
        post({tag, "_acc"}, 0, 5'd0, 32'h0);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        pre({tag, "_win"}, 0, 1);
        post({tag, "_win"}, 1, rd, exp);
    endtask

    initial begin
        // Reset held two cycles with traffic present
        rst = 1'b0;
        idle();
        drv_ld(1, 5'd3, 32'h1234_5678, 3'b010, 2'd0);
        drv_ex(1, 5'd1, 32'h1);
        repeat (2) @(negedge clk);
        chk("rst_wen",   32'(bus.rd_wen_o),   32'h0);
        chk("rst_waddr", 32'(bus.rd_waddr_o), 32'h0);
        chk("rst_wdata", bus.rd_wdata_o,      32'h0);
        chk("rst_busy",  bus.busy_o,          32'h0);
        rst = 1'b1;
        idle();
        pre("rst_rel", 0, 1);
        post("rst_empty", 0, 5'd0, 32'h0);

        // Load extension
        do_load("lb",   5'd3, 32'h8070_F0AA, F3_LB,  2'd1, 32'hFFFF_FFF0);
        do_load("lhu",  5'd4, 32'h8070_F0AA, F3_LHU, 2'd2, 32'h0000_8070);
        do_load("lw",   5'd5, 32'h8070_F0AA, F3_LW,  2'd0, 32'h8070_F0AA);
        do_load("lh",   5'd6, 32'h8070_F0AA, F3_LH,  2'd0, 32'hFFFF_F0AA);
        do_load("lbu",  5'd8, 32'h8070_F0AA, F3_LBU, 2'd3, 32'h0000_0080);
        do_load("f111", 5'd9, 32'h8070_F0AA, 3'b111, 2'd1, 32'h8070_F0AA);
        post("hold", 0, 5'd0, 32'h0);
        chk("hold_waddr", 32'(bus.rd_waddr_o), 32'd9);
        chk("hold_wdata", bus.rd_wdata_o,      32'h8070_F0AA);

        // Starvation guard: load waits behind three EX wins, then is forced through
        drv_ld(1, 5'd9, 32'h1111_1111, F3_LW, 2'd0);
        for (int i = 0; i < 4; i++) begin
            drv_ex(1, 5'(10 + i), 32'(32'hA0 + i));
            pre($sformatf("starve_ex%0d", i), 0, 1);
            post($sformatf("starve_ex%0d", i), 1, 5'(10 + i), 32'(32'hA0 + i));
            if (i == 0) drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        end
        drv_ex(1, 5'd14, 32'hA4);
        pre("starve_stall", 1, 1);
        post("starve_ld", 1, 5'd9, 32'h1111_1111);
        pre("starve_resume", 0, 1);
        post("starve_resume", 1, 5'd14, 32'hA4);
        idle();

        // Backpressure: continuous EX, three back-to-back load beats
        drv_ex(1, 5'd16, 32'hB0); drv_ld(1, 5'd20, 32'hC0, F3_LW, 2'd0);
        pre("bp0", 0, 1); post("bp0", 1, 5'd16, 32'hB0);
        drv_ex(1, 5'd17, 32'hB1); drv_ld(1, 5'd21, 32'hC1, F3_LW, 2'd0);
        pre("bp1", 0, 1); post("bp1", 1, 5'd17, 32'hB1);
        drv_ex(1, 5'd18, 32'hB2); drv_ld(1, 5'd22, 32'hC2, F3_LW, 2'd0);
        pre("bp2", 0, 0); post("bp2", 1, 5'd18, 32'hB2);
        drv_ex(1, 5'd19, 32'hB3);
        pre("bp3", 0, 0); post("bp3", 1, 5'd19, 32'hB3);
        drv_ex(1, 5'd24, 32'hB4);
        pre("bp4", 1, 0); post("bp4", 1, 5'd20, 32'hC0);
        pre("bp5", 0, 1); post("bp5", 1, 5'd24, 32'hB4);
        idle();
        pre("bp6", 0, 0); post("bp6", 1, 5'd21, 32'hC1);
        pre("bp7", 0, 1); post("bp7", 1, 5'd22, 32'hC2);
        pre("bp8", 0, 1); post("bp8", 0, 5'd0, 32'h0);

        // Scoreboard set / clear
        drv_iss(1, 5'd7);
        post("sb_iss", 0, 5'd0, 32'h0);
        chk("sb_busy_set", bus.busy_o, 32'h0000_0080);
        drv_iss(0, 5'd0); drv_ld(1, 5'd7, 32'h77, F3_LW, 2'd0);
        post("sb_acc", 0, 5'd0, 32'h0);
        chk("sb_busy_wait", bus.busy_o, 32'h0000_0080);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        post("sb_win", 1, 5'd7, 32'h77);
        chk("sb_busy_clr", bus.busy_o, 32'h0);

        // Re-issue in the same cycle the previous load to x7 retires: set wins
        drv_iss(1, 5'd7);
        post("sb_iss2", 0, 5'd0, 32'h0);
        drv_iss(0, 5'd0); drv_ld(1, 5'd7, 32'h78, F3_LW, 2'd0);
        post("sb_acc2", 0, 5'd0, 32'h0);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0); drv_iss(1, 5'd7);
        post("sb_setclr", 1, 5'd7, 32'h78);
        chk("sb_busy_setwins", bus.busy_o, 32'h0000_0080);
        drv_iss(0, 5'd0); drv_ld(1, 5'd7, 32'h79, F3_LW, 2'd0);
        post("sb_acc3", 0, 5'd0, 32'h0);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        post("sb_win3", 1, 5'd7, 32'h79);
        chk("sb_busy_final", bus.busy_o, 32'h0);

        // x0: EX write and load both suppressed, FIFO entry still consumed
        drv_ex(1, 5'd0, 32'hDEAD);
        post("x0_ex", 0, 5'd0, 32'h0);
        drv_ex(0, 5'd0, 32'h0); drv_iss(1, 5'd0);
        post("x0_iss", 0, 5'd0, 32'h0);
        chk("x0_busy", bus.busy_o, 32'h0);
        drv_iss(0, 5'd0); drv_ld(1, 5'd0, 32'h55, F3_LW, 2'd0);
        post("x0_acc", 0, 5'd0, 32'h0);
        drv_ld(0, 5'd0, 32'h0, 3'b010, 2'd0);
        post("x0_win", 0, 5'd0, 32'h0);
        do_load("x0_after", 5'd3, 32'h33, F3_LW, 2'd0, 32'h33);

        // Reset mid-operation drops the queued load and pending busy bits
        drv_iss(1, 5'd13); drv_ld(1, 5'd12, 32'hCC, F3_LW, 2'd0);
        post("mid_acc", 0, 5'd0, 32'h0);
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_wen",  32'(bus.rd_wen_o), 32'h0);
        chk("mid_rst_busy", bus.busy_o,        32'h0);
        rst = 1'b1;
        pre("mid_rel", 0, 1);
        post("mid_flushed", 0, 5'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
